// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: word-addressed PC, synchronous-read BRAM addressing,
// IF/ID pipeline register with bubble insertion, and fetch/redirect counters.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_F,
   input  logic              stall_D,
   input  logic              flush_D,
   input  logic              PC_src_D,
   input  logic [31:0]       PC_Target_D,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       PC_F,
   output logic [31:0]       PC_D,
   output logic [31:0]       instr_D,
   output logic              valid_D,
   output logic [31:0]       fetch_count,
   output logic [31:0]       redirect_count
);

   logic [31:0] pc_f_p0;
   logic [31:0] next_pc;
   logic [31:0] pc_d_p1;
   logic [31:0] instr_d_p1;
   logic        vld_p1;
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;
   logic        redirect_acc;
   logic        bubble_d;
   logic        load_d;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd1;
   endfunction

   function automatic logic [31:0] cnt_inc(input logic [31:0] cnt);
      return cnt + 32'd1;
   endfunction

   // Decode operands are not final while decode is stalled, so the redirect waits.
   assign redirect_acc = PC_src_D & ~stall_D;

   always_comb begin
      next_pc = pc_inc(pc_f_p0);
      if (rst)
         next_pc = RESET_PC;
      else if (redirect_acc)
         next_pc = PC_Target_D;
      else if (stall_F)
         next_pc = pc_f_p0;
   end

   // Addressing the BRAM with next_pc makes imem_rdata line up with PC_F.
   assign imem_addr = next_pc[ADDR_W-1:0];

   always_comb begin
      bubble_d = 1'b0;
      load_d   = 1'b0;
      if (redirect_acc || flush_D)
         bubble_d = 1'b1;
      else if (stall_D)
         bubble_d = 1'b0;
      else if (stall_F)
         bubble_d = 1'b1;
      else
         load_d = 1'b1;
   end

   // Stage p0: program counter
   always_ff @(posedge clk) begin
      pc_f_p0 <= next_pc;
   end

   // Stage p1: IF/ID register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_d_p1    <= 32'd0;
         instr_d_p1 <= NOP_INSTR;
         vld_p1     <= 1'b0;
      end else if (bubble_d) begin
         pc_d_p1    <= pc_f_p0;
         instr_d_p1 <= NOP_INSTR;
         vld_p1     <= 1'b0;
      end else if (load_d) begin
         pc_d_p1    <= pc_f_p0;
         instr_d_p1 <= imem_rdata;
         vld_p1     <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt    <= 32'd0;
         redirect_cnt <= 32'd0;
      end else begin
         if (load_d)
            fetch_cnt <= cnt_inc(fetch_cnt);
         if (redirect_acc)
            redirect_cnt <= cnt_inc(redirect_cnt);
      end
   end

   assign PC_F           = pc_f_p0;
   assign PC_D           = pc_d_p1;
   assign instr_D        = instr_d_p1;
   assign valid_D        = vld_p1;
   assign fetch_count    = fetch_cnt;
   assign redirect_count = redirect_cnt;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the decode-stage branch/jump unit.
- Owns the word-addressed program counter and drives the synchronous-read instruction BRAM.
- Holds the IF/ID pipeline register that produces PC_D and instr_D for decode.
- Consumes the decode-stage redirect (PC_src_D, PC_Target_D) and the hazard unit's stall/flush controls; also keeps fetch/redirect performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, word address loaded into the PC on reset.
- ADDR_W, 12, width of the instruction-memory word address.
- NOP_INSTR, 32'h0000_0013, instruction placed in instr_D on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_F  in  1  hold the PC (hazard unit).
- stall_D  in  1  hold the IF/ID register (hazard unit).
- flush_D  in  1  insert a bubble into IF/ID (hazard unit).
- PC_src_D  in  1  redirect request from decode.
- PC_Target_D  in  32  redirect target, word address.
- imem_addr  out  ADDR_W  BRAM read address (combinational).
- imem_rdata  in  32  BRAM read data; 1-cycle latency from imem_addr.
- PC_F  out  32  current fetch PC, word address.
- PC_D  out  32  PC of the instruction in decode.
- instr_D  out  32  instruction in decode.
- valid_D  out  1  instr_D is a real instruction (0 = bubble).
- fetch_count  out  32  count of valid instructions loaded into IF/ID.
- redirect_count  out  32  count of accepted redirects.

Behaviour:
- Reset values:
  - PC_F = RESET_PC.
  - PC_D = 0, instr_D = NOP_INSTR, valid_D = 0.
  - fetch_count = 0, redirect_count = 0.
  - During rst, imem_addr = RESET_PC[ADDR_W-1:0].
- Redirect acceptance: redirect_acc = PC_src_D & ~stall_D. PC_src_D is ignored while stall_D=1, because decode operands are not final.
- Next-PC selection, in priority order:
  - rst -> RESET_PC.
  - redirect_acc -> PC_Target_D. This overrides stall_F.
  - stall_F -> PC_F.
  - otherwise -> PC_F + 1, 32-bit modulo; 32'hFFFF_FFFF wraps to 0.
- imem_addr = next_pc[ADDR_W-1:0].
  - This makes imem_rdata in cycle t the word at PC_F of cycle t.
  - On stall the same address is re-read, so no skid buffer is needed.
  - Upper PC bits beyond ADDR_W are ignored when addressing memory.
- IF/ID update, in priority order:
  - rst -> reset values.
  - redirect_acc or flush_D -> bubble: valid_D=0, instr_D=NOP_INSTR, PC_D=PC_F.
  - stall_D -> hold all three registers. flush_D still wins over stall_D.
  - stall_F with no stall_D -> bubble.
  - otherwise -> PC_D=PC_F, instr_D=imem_rdata, valid_D=1.
- Latency:
  - An instruction at address A appears in instr_D one cycle after PC_F=A, when there is no stall.
  - Redirect penalty is exactly one bubble: the cycle after acceptance has PC_F=target and valid_D=0; the target instruction reaches decode one cycle later.
- First fetch after reset: the first cycle with rst=0 has PC_F=RESET_PC and a valid imem_rdata, so valid_D rises on the following edge.
- Counters:
  - fetch_count increments on each edge where IF/ID loads with valid_D becoming 1.
  - redirect_count increments on each edge with redirect_acc.
  - Both wrap modulo 2^32. Neither changes during reset.
- Simultaneous events:
  - redirect_acc with stall_F: redirect wins.
  - redirect with flush_D: single bubble; counted as one redirect.
- Reset mid-stall or mid-redirect: rst overrides everything on that edge.

Test Plan:
1. Reset and sequential fetch: assert rst for 2 cycles, RESET_PC=0x10, memory word k = 0xA000_0000+k. Required response: PC_F = 0x10,0x11,0x12; instr_D/PC_D = 0xA000_0010/0x10, then 0xA000_0011/0x11; valid_D=0 only in the first post-reset cycle; fetch_count=2 after two loads.
2. Redirect taken: with PC_F=0x14, pulse PC_src_D=1 and PC_Target_D=0x40 for one cycle (stall_D=0). Required response: next cycle PC_F=0x40, valid_D=0, instr_D=0x13; following cycle instr_D=0xA000_0040 with PC_D=0x40; redirect_count=1.
3. Load-use stall: hold stall_F=stall_D=1 for 3 cycles at PC_F=0x20. Required response: PC_F, PC_D and instr_D unchanged and imem_addr=0x20 throughout; after release, fetch resumes at 0x21 with no duplicated or lost instruction.
4. Redirect during stall_D: set PC_src_D=1, stall_D=1, Target=0x80. Required response: PC_F holds and redirect_count is unchanged. Then drop stall_D with PC_src_D still 1: redirect to 0x80 is accepted.
5. Priority: set flush_D=1 with stall_D=1, then rst=1 together with PC_src_D=1. Required response: the flush produces a bubble despite the stall; on the rst edge PC_F=RESET_PC and redirect_count is not incremented.
6. Wrap: force PC_F=0xFFFF_FFFF via redirect. Required response: next PC_F=0x0000_0000 and imem_addr=0.
